// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// Moore phase scheduler for one intersection. The main road (NS) rests on
// green; the side road (EW) and an optional pedestrian walk phase are served
// only when a latched request is pending. Conflicting greens are always
// separated by a yellow phase and an all-red clearance phase.
//
// Build option:
//   PED_REQ_EN  - when defined, the pedestrian request latch and the WALK
//                 phase are compiled in. When undefined, ped_btn is ignored,
//                 WALK is unreachable and walk is tied low. Ports are the
//                 same in both builds.
//
// Parameters:
//   T_INIT  all-red cycles after reset release
//   G_MIN   minimum NS green cycles before yielding
//   T_EWG   EW green cycles
//   T_Y     yellow cycles (both heads)
//   T_CLR   all-red clearance cycles
//   T_WALK  pedestrian walk cycles
//   TW      timer width; every duration must lie in 1..2**TW-1
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   ew_req    in   side-road vehicle sensor, sampled each edge
//   ped_btn   in   pedestrian button, sampled each edge
//   ns_light  out  NS head: 00 RED, 01 GREEN, 10 YELLOW
//   ew_light  out  EW head, same encoding
//   walk      out  walk signal
//   phase     out  current state encoding (debug)
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl #(
  parameter int T_INIT = 4,
  parameter int G_MIN  = 4,
  parameter int T_EWG  = 4,
  parameter int T_Y    = 4,
  parameter int T_CLR  = 2,
  parameter int T_WALK = 6,
  parameter int TW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_req,
  input  logic       ped_btn,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INIT_RED  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    CLR1      = 3'd3,
    WALK      = 3'd4,
    EW_GREEN  = 3'd5,
    EW_YELLOW = 3'd6,
    CLR2      = 3'd7
  } state_e;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  // The timer reads 0 in the cycle after entry, so a phase of length T is
  // left on the edge where the timer already shows T-1.
  localparam logic [TW-1:0] INIT_LAST = TW'(T_INIT - 1);
  localparam logic [TW-1:0] GMIN_LAST = TW'(G_MIN - 1);
  localparam logic [TW-1:0] GMIN_SAT  = TW'(G_MIN);
  localparam logic [TW-1:0] EWG_LAST  = TW'(T_EWG - 1);
  localparam logic [TW-1:0] Y_LAST    = TW'(T_Y - 1);
  localparam logic [TW-1:0] CLR_LAST  = TW'(T_CLR - 1);
  localparam logic [TW-1:0] WALK_LAST = TW'(T_WALK - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ew_pend_q, ew_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          gmin_met;
  logic          entering;

  // NS may yield on the edge that completes its G_MIN-th green cycle; the
  // timer saturates at G_MIN so this stays true while green is held.
  assign gmin_met = (timer_q >= GMIN_LAST);

  // Next-state logic. Only the registered pending bits steer transitions,
  // so a request always takes at least one edge to be acted on.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_RED: begin
        if (timer_q == INIT_LAST) state_d = NS_GREEN;
      end
      NS_GREEN: begin
        if (gmin_met && (ew_pend_q || ped_pend_q)) state_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (timer_q == Y_LAST) state_d = CLR1;
      end
      CLR1: begin
        // Pedestrian is served ahead of the side road when both wait.
        if (timer_q == CLR_LAST) state_d = ped_pend_q ? WALK : EW_GREEN;
      end
      WALK: begin
        if (timer_q == WALK_LAST) state_d = ew_pend_q ? EW_GREEN : NS_GREEN;
      end
      EW_GREEN: begin
        if (timer_q == EWG_LAST) state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (timer_q == Y_LAST) state_d = CLR2;
      end
      CLR2: begin
        if (timer_q == CLR_LAST) state_d = NS_GREEN;
      end
      default: state_d = INIT_RED;
    endcase
  end

  assign entering = (state_d != state_q);

  // Phase timer: restarts on every state change, otherwise counts up.
  // Only NS_GREEN can dwell past its limit, so only it needs saturation.
  always_comb begin
    timer_d = timer_q + TMR_ONE;
    if (entering) begin
      timer_d = '0;
    end else if (state_q == NS_GREEN && timer_q == GMIN_SAT) begin
      timer_d = timer_q;
    end
  end

  // Request latches. A request arriving while its own phase is active is
  // dropped; the clear on phase entry wins over a simultaneous set.
  always_comb begin
    ew_pend_d = ew_pend_q;
    if (ew_req && state_q != EW_GREEN) ew_pend_d = 1'b1;
    if (entering && state_d == EW_GREEN) ew_pend_d = 1'b0;
  end

`ifdef PED_REQ_EN
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_btn && state_q != WALK) ped_pend_d = 1'b1;
    if (entering && state_d == WALK) ped_pend_d = 1'b0;
  end
`else
  // Button is not used in this build; the latch is held clear.
  logic unused_ped_btn;
  assign unused_ped_btn = ped_btn;
  assign ped_pend_d     = 1'b0;
`endif

  // State, timer and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT_RED;
      timer_q    <= '0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Moore output decode straight from the state register; inputs never
  // reach the outputs combinationally.
  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    walk     = 1'b0;
    unique case (state_q)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef PED_REQ_EN
      WALK:      walk     = 1'b1;
`endif
      default: begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//
// Self-checking bench for traffic_intersection_ctrl. A behavioural model
// tracks which phase the intersection is in and how many edges it has been
// there, applying the phase-length and request rules directly. Scenario
// tasks also compare against hand-derived edge numbers.
// ---------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

  localparam int T_INIT = 4;
  localparam int G_MIN  = 4;
  localparam int T_EWG  = 4;
  localparam int T_Y    = 4;
  localparam int T_CLR  = 2;
  localparam int T_WALK = 6;

`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;

  // Model phase names (bench-local numbering).
  localparam int P_INIT = 0;
  localparam int P_NSG  = 1;
  localparam int P_NSY  = 2;
  localparam int P_CLR1 = 3;
  localparam int P_WALK = 4;
  localparam int P_EWG  = 5;
  localparam int P_EWY  = 6;
  localparam int P_CLR2 = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ew_req = 1'b0;
  logic       ped_btn = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  int vectors = 0;
  int miscompares = 0;
  int edgeNo = 0;

  int mPhase = P_INIT;
  int mAge = 0;
  bit mEw = 1'b0;
  bit mPed = 1'b0;

  traffic_intersection_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ew_req   (ew_req),
    .ped_btn  (ped_btn),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  function automatic int phaseLen(int p);
    case (p)
      P_INIT:        return T_INIT;
      P_NSY, P_EWY:  return T_Y;
      P_CLR1, P_CLR2: return T_CLR;
      P_WALK:        return T_WALK;
      P_EWG:         return T_EWG;
      default:       return 0;
    endcase
  endfunction

  function automatic logic [4:0] mdlOut();
    case (mPhase)
      P_NSG:   return {GRN, RED, 1'b0};
      P_NSY:   return {YEL, RED, 1'b0};
      P_EWG:   return {RED, GRN, 1'b0};
      P_EWY:   return {RED, YEL, 1'b0};
      P_WALK:  return {RED, RED, 1'b1};
      default: return {RED, RED, 1'b0};
    endcase
  endfunction

  task automatic mdlReset();
    mPhase = P_INIT;
    mAge   = 0;
    mEw    = 1'b0;
    mPed   = 1'b0;
  endtask

  // One clock edge of the model; mAge counts edges spent in the phase.
  task automatic mdlStep(input bit ewIn, input bit pedIn);
    int nxt;
    int age1;
    bit e;
    bit pd;
    age1 = mAge + 1;
    e    = mEw | (ewIn && mPhase != P_EWG);
    pd   = PED && (mPed | (pedIn && mPhase != P_WALK));
    nxt  = mPhase;
    if (mPhase == P_NSG) begin
      if (age1 >= G_MIN && (mEw || mPed)) nxt = P_NSY;
    end else if (age1 == phaseLen(mPhase)) begin
      case (mPhase)
        P_INIT: nxt = P_NSG;
        P_NSY:  nxt = P_CLR1;
        P_CLR1: nxt = mPed ? P_WALK : P_EWG;
        P_WALK: nxt = mEw ? P_EWG : P_NSG;
        P_EWG:  nxt = P_EWY;
        P_EWY:  nxt = P_CLR2;
        default: nxt = P_NSG;
      endcase
    end
    if (nxt != mPhase) begin
      mAge = 0;
      if (nxt == P_EWG)  e  = 1'b0;
      if (nxt == P_WALK) pd = 1'b0;
    end else begin
      mAge = age1;
    end
    mPhase = nxt;
    mEw    = e;
    mPed   = pd;
  endtask

  // Advance one edge, update the model, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    if (rst) mdlStep(ew_req, ped_btn);
    else     mdlReset();
    edgeNo++;
    #1;
  endtask

  // Reset pulse spanning two edges; the next edge after return is E1.
  task automatic restart();
    rst = 1'b0;
    mdlReset();
    tick();
    tick();
    rst = 1'b1;
    edgeNo = 0;
  endtask

  task automatic test_reset();
    logic [1:0] expNs;
    #2 rst = 1'b0;
    mdlReset();
    #2;
    vectors++;
    if ({ns_light, ew_light, walk} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b want %b", {ns_light, ew_light, walk}, 5'b0);
    end
    tick();
    rst = 1'b1;
    edgeNo = 0;
    ew_req = 1'b0;
    ped_btn = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      expNs = (e >= 4) ? GRN : RED;
      vectors++;
      if ({ns_light, ew_light, walk} !== {expNs, RED, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_release E%0d: got %b want %b", e, {ns_light, ew_light, walk}, {expNs, RED, 1'b0});
      end
      vectors++;
      if ({ns_light, ew_light, walk} !== mdlOut()) begin
        miscompares++;
        $display("[TB] FAIL reset_model E%0d: got %b want %b", e, {ns_light, ew_light, walk}, mdlOut());
      end
    end
  endtask

  task automatic test_ew_request(input bit held);
    logic [1:0] expNs;
    logic [1:0] expEw;
    restart();
    for (int e = 1; e <= 40; e++) begin
      ew_req = held ? (e >= 10) : (e == 10);
      tick();
      expNs = RED;
      expEw = RED;
      if (e >= 4 && e < 11)                     expNs = GRN;
      else if (e >= 11 && e < 15)               expNs = YEL;
      else if (e >= 27 && (!held || e < 31))    expNs = GRN;
      else if (held && e >= 31 && e < 35)       expNs = YEL;
      if (e >= 17 && e < 21)                    expEw = GRN;
      else if (e >= 21 && e < 25)               expEw = YEL;
      else if (held && e >= 37)                 expEw = GRN;
      vectors++;
      if ({ns_light, ew_light, walk} !== {expNs, expEw, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL ew_req(held=%0d) E%0d: got %b want %b", held, e, {ns_light, ew_light, walk}, {expNs, expEw, 1'b0});
      end
      vectors++;
      if ({ns_light, ew_light, walk} !== mdlOut()) begin
        miscompares++;
        $display("[TB] FAIL ew_model(held=%0d) E%0d: got %b want %b", held, e, {ns_light, ew_light, walk}, mdlOut());
      end
    end
    ew_req = 1'b0;
  endtask

  task automatic test_ped();
    logic [4:0] exp;
    restart();
    for (int e = 1; e <= 40; e++) begin
`ifdef PED_REQ_EN
      ew_req = (e == 10);
`endif
      ped_btn = (e == 10);
      tick();
`ifdef PED_REQ_EN
      exp = {RED, RED, 1'b0};
      if ((e >= 4 && e < 11) || e >= 33) exp = {GRN, RED, 1'b0};
      else if (e >= 11 && e < 15)        exp = {YEL, RED, 1'b0};
      else if (e >= 17 && e < 23)        exp = {RED, RED, 1'b1};
      else if (e >= 23 && e < 27)        exp = {RED, GRN, 1'b0};
      else if (e >= 27 && e < 31)        exp = {RED, YEL, 1'b0};
`else
      exp = (e >= 4) ? {GRN, RED, 1'b0} : {RED, RED, 1'b0};
`endif
      vectors++;
      if ({ns_light, ew_light, walk} !== exp) begin
        miscompares++;
        $display("[TB] FAIL ped E%0d: got %b want %b", e, {ns_light, ew_light, walk}, exp);
      end
      vectors++;
      if ({ns_light, ew_light, walk} !== mdlOut()) begin
        miscompares++;
        $display("[TB] FAIL ped_model E%0d: got %b want %b", e, {ns_light, ew_light, walk}, mdlOut());
      end
    end
    ew_req = 1'b0;
    ped_btn = 1'b0;
  endtask

  // Reset during EW green, then reset with a request pending but not yet
  // served: after each release NS must rest on green with no EW grant.
  task automatic test_reset_midrun();
    logic [1:0] expNs;
    for (int pass = 0; pass < 2; pass++) begin
      restart();
      for (int e = 1; e <= ((pass == 0) ? 19 : 3); e++) begin
        ew_req = (pass == 0) ? (e == 10) : (e == 2);
        tick();
      end
      ew_req = 1'b0;
      vectors++;
      if (pass == 0 && ew_light !== GRN) begin
        miscompares++;
        $display("[TB] FAIL pre_reset_ewg: got %b want %b", ew_light, GRN);
      end
      rst = 1'b0;
      mdlReset();
      #1;
      vectors++;
      if ({ns_light, ew_light, walk} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL async_reset pass%0d: got %b want %b", pass, {ns_light, ew_light, walk}, 5'b0);
      end
      tick();
      rst = 1'b1;
      edgeNo = 0;
      for (int e = 1; e <= 40; e++) begin
        tick();
        expNs = (e >= 4) ? GRN : RED;
        vectors++;
        if ({ns_light, ew_light, walk} !== {expNs, RED, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL after_reset pass%0d E%0d: got %b want %b", pass, e, {ns_light, ew_light, walk}, {expNs, RED, 1'b0});
        end
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 3000; i++) begin
      ew_req  = ($urandom_range(0, 11) == 0);
      ped_btn = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        mdlReset();
        #2;
        vectors++;
        if ({ns_light, ew_light, walk} !== 5'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_reset i=%0d: got %b want %b", i, {ns_light, ew_light, walk}, 5'b0);
        end
        tick();
        rst = 1'b1;
      end else begin
        tick();
        vectors++;
        if ({ns_light, ew_light, walk} !== mdlOut()) begin
          miscompares++;
          $display("[TB] FAIL rand_model i=%0d: got %b want %b", i, {ns_light, ew_light, walk}, mdlOut());
        end
        vectors++;
        if ((ns_light !== RED && ew_light !== RED) || (walk !== 1'b0 && (ns_light !== RED || ew_light !== RED))) begin
          miscompares++;
          $display("[TB] FAIL rand_safety i=%0d: got ns=%b ew=%b walk=%b want no conflict", i, ns_light, ew_light, walk);
        end
      end
    end
    ew_req = 1'b0;
    ped_btn = 1'b0;
  endtask

  initial begin
    $display("[TB] start, PED_REQ_EN=%0d", PED);
    test_reset();
    test_ew_request(1'b0);
    test_ew_request(1'b1);
    test_ped();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
